// File: rtl/prog_truth_table_if.sv
// prog_truth_table_if: config, eval stream and sweep signals of the truth-table engine; master drives requests, slave is the engine
interface prog_truth_table_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1
);
  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  logic              cfg_we;
  logic [N_IN-1:0]   cfg_addr;
  logic [N_OUT-1:0]  cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_data;
  logic              sweep_start;
  logic [SEL_W-1:0]  sweep_sel;
  logic              sweep_busy;
  logic              sweep_done;
  logic [N_IN:0]     sweep_count;
  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready, sweep_start, sweep_sel,
    input  in_ready, out_valid, out_data, sweep_busy, sweep_done, sweep_count
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready, sweep_start, sweep_sel,
    output in_ready, out_valid, out_data, sweep_busy, sweep_done, sweep_count
  );
endinterface

// File: rtl/prog_truth_table.sv
// prog_truth_table: programmable registered LUT with valid/ready eval, config writes and a column minterm-count sweep; ports clk, rst_n (async low), bus (slave: cfg_*, in_*, out_*, sweep_*)
module prog_truth_table #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter logic [(2**N_IN)*N_OUT-1:0] INIT = 16'hFC55
) (
  input logic clk,
  input logic rst_n,
  prog_truth_table_if.slave bus
);
  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, state_nx;
  logic [N_OUT-1:0] tbl [2**N_IN];
  logic [N_IN-1:0] idx;
  logic [N_IN:0] cnt;
  logic [SEL_W-1:0] sel_q;
  logic ov, col_bit, accept;
  logic [N_OUT-1:0] od;
  assign accept = bus.in_valid & bus.in_ready;
  // selects with no matching column (sel >= N_OUT) contribute nothing
  always_comb begin
    col_bit = 1'b0;
    for (int k = 0; k < N_OUT; k++)
      if (sel_q == SEL_W'(k)) col_bit = tbl[idx][k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE)  ? (bus.sweep_start ? SWEEP : IDLE) :
               (state == SWEEP) ? (&idx ? DONE : SWEEP) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2**N_IN; i++) tbl[i] <= INIT[i*N_OUT +: N_OUT];
      ov <= 1'b0;
      od <= '0;
      idx <= '0;
      cnt <= '0;
      sel_q <= '0;
    end else begin
      if (accept) begin
        ov <= 1'b1;
        od <= tbl[bus.in_data];
      end else if (bus.out_ready) ov <= 1'b0;
      // eval above reads the pre-write entry when both hit the same address
      if (bus.cfg_we && state != SWEEP) tbl[bus.cfg_addr] <= bus.cfg_data;
      if (state == IDLE && bus.sweep_start) begin
        sel_q <= bus.sweep_sel;
        cnt <= '0;
        idx <= '0;
      end else if (state == SWEEP) begin
        cnt <= cnt + (N_IN+1)'(col_bit);
        idx <= idx + 1'b1;
      end
    end
  always_comb begin
    bus.in_ready = (state != SWEEP) & (~ov | bus.out_ready);
    bus.out_valid = ov;
    bus.out_data = od;
    bus.sweep_busy = state == SWEEP;
    bus.sweep_done = state == DONE;
    bus.sweep_count = cnt;
  end
endmodule
